// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared fetch-stage constants and FSM state type
package instr_fetch_unit_pkg;

    localparam int IFU_ADDR_W  = 16;
    localparam int IFU_INSTR_W = 16;

    localparam logic [IFU_INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/ready bus
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = IFU_ADDR_W,
    parameter int INSTR_W = IFU_INSTR_W
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// rtl/instr_fetch_unit_pc_reg.sv - program counter with hold, increment and load
module instr_fetch_unit_pc_reg #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc
);
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Load wins over increment; the increment wraps naturally at 2^ADDR_W.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (incr) begin
            pc <= pc + ONE;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, imem request FSM, output slot, redirect flush
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter int                INSTR_W  = IFU_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pc_write,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    instr_fetch_unit_if.master imem,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [ADDR_W-1:0]  instr_addr_out,
    output logic               fetch_valid,
    output logic               if_flush
);
    fetch_state_t      state, state_nxt;
    logic              req;
    logic              transfer;
    logic              redirect;
    logic [ADDR_W-1:0] pc;

    assign redirect = branch_taken && (state != S_INIT);
    assign transfer = req && imem.imem_ready;

    // req comes straight from the state register so reset kills it without a clock edge.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        case (state)
            S_INIT: state_nxt = S_FETCH;
            S_FETCH: begin
                req = !fetch_valid || pc_write;
                if (fetch_valid && !pc_write) begin
                    state_nxt = S_STALL;
                end
            end
            S_STALL: begin
                if (pc_write) begin
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_INIT;
        endcase
        if (redirect) begin
            state_nxt = S_FETCH;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    instr_fetch_unit_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (redirect),
        .load_value (branch_target),
        .incr       (transfer && !redirect),
        .pc         (pc)
    );

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    // A redirect drops whatever memory returned this cycle; the slot only ever holds NOP when empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instruction_out <= NOP_INSTR;
            instr_addr_out  <= '0;
            fetch_valid     <= 1'b0;
            if_flush        <= 1'b0;
        end else begin
            if_flush <= redirect;
            if (redirect) begin
                instruction_out <= NOP_INSTR;
                instr_addr_out  <= '0;
                fetch_valid     <= 1'b0;
            end else if (transfer) begin
                instruction_out <= imem.imem_rdata;
                instr_addr_out  <= pc;
                fetch_valid     <= 1'b1;
            end else if (pc_write) begin
                instruction_out <= NOP_INSTR;
                instr_addr_out  <= '0;
                fetch_valid     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pc_write = 1'b1;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        ready = 1'b1;
    logic [15:0] instruction_out, instr_addr_out;
    logic        fetch_valid, if_flush;

    logic [15:0] instruction_out2, instr_addr_out2;
    logic        fetch_valid2, if_flush2;
    logic        tie_one = 1'b1;
    logic        tie_zero = 1'b0;
    logic [15:0] tie_target = 16'h0000;

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus2 ();

    assign bus.imem_ready  = ready;
    assign bus.imem_rdata  = bus.imem_addr + 16'h1000;
    assign bus2.imem_ready = tie_one;
    assign bus2.imem_rdata = bus2.imem_addr + 16'h1000;

    instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_write        (pc_write),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem            (bus.master),
        .instruction_out (instruction_out),
        .instr_addr_out  (instr_addr_out),
        .fetch_valid     (fetch_valid),
        .if_flush        (if_flush)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clock           (clock),
        .reset           (reset),
        .pc_write        (tie_one),
        .branch_taken    (tie_zero),
        .branch_target   (tie_target),
        .imem            (bus2.master),
        .instruction_out (instruction_out2),
        .instr_addr_out  (instr_addr_out2),
        .fetch_valid     (fetch_valid2),
        .if_flush        (if_flush2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: first clock after reset only arms fetching; a held slot
    // (not taken across an edge) blocks requests until the buffer takes it.
    logic        m_started, m_held, m_valid, m_flush;
    logic [15:0] m_pc, m_instr, m_addr;

    function automatic logic model_req();
        if (!m_started || m_held) return 1'b0;
        return !m_valid || pc_write;
    endfunction

    always @(posedge clock or negedge reset) begin
        logic xfer;
        if (!reset) begin
            m_started = 0; m_held = 0; m_valid = 0; m_flush = 0;
            m_pc = 16'h0000; m_instr = 16'h0; m_addr = 16'h0;
        end else if (!m_started) begin
            m_started = 1;
            m_flush = 0;
        end else if (branch_taken) begin
            m_pc = branch_target; m_valid = 0; m_instr = 0; m_addr = 0;
            m_flush = 1; m_held = 0;
        end else begin
            xfer = model_req() && ready;
            m_flush = 0;
            m_held = m_valid && !pc_write;
            if (xfer) begin
                m_instr = bus.imem_rdata; m_addr = m_pc; m_valid = 1; m_pc = m_pc + 16'h1;
            end else if (pc_write) begin
                m_instr = 0; m_addr = 0; m_valid = 0;
            end
        end
    end

    always @(negedge clock) begin
        check("req",   {31'b0, bus.imem_req}, {31'b0, model_req()});
        check("addr",  {16'b0, bus.imem_addr}, {16'b0, m_pc});
        check("instr", {16'b0, instruction_out}, {16'b0, m_instr});
        check("iaddr", {16'b0, instr_addr_out}, {16'b0, m_addr});
        check("valid", {31'b0, fetch_valid}, {31'b0, m_valid});
        check("flush", {31'b0, if_flush}, {31'b0, m_flush});
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin : wrap_check
        logic [15:0] exp_seq [3];
        int n;
        exp_seq[0] = 16'hFFFE; exp_seq[1] = 16'hFFFF; exp_seq[2] = 16'h0000;
        @(posedge reset);
        n = 0;
        while (!fetch_valid2 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("wrap_timeout", {31'b0, fetch_valid2}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("wrap_seq", {16'b0, instr_addr_out2}, {16'b0, exp_seq[i]});
            @(negedge clock);
        end
    end

    initial begin
        logic [15:0] pat_pw, pat_rd;
        pat_pw = 16'b1011_0111_1100_1101;
        pat_rd = 16'b1101_1010_0111_0110;

        step(); step();
        check("rst_req", {31'b0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'b0, fetch_valid}, 32'd0);
        reset = 1'b1;
        check("init_req", {31'b0, bus.imem_req}, 32'd0);
        step();
        check("first_req", {31'b0, bus.imem_req}, 32'd1);
        check("first_addr", {16'b0, bus.imem_addr}, 32'h0);
        step();
        check("slot0_addr", {16'b0, instr_addr_out}, 32'h0);
        check("slot0_instr", {16'b0, instruction_out}, 32'h1000);
        step(); step(); step(); step();
        check("pc5", {16'b0, bus.imem_addr}, 32'h5);

        ready = 1'b0;
        step();
        check("rdy0_valid", {31'b0, fetch_valid}, 32'd0);
        step(); step();
        check("rdy0_addr", {16'b0, bus.imem_addr}, 32'h5);
        ready = 1'b1;
        step();
        check("slot5", {16'b0, instruction_out}, 32'h1005);
        step(); step();
        check("slot7", {16'b0, instr_addr_out}, 32'h7);

        pc_write = 1'b0;
        repeat (4) begin
            step();
            check("stall_iaddr", {16'b0, instr_addr_out}, 32'h7);
            check("stall_pc", {16'b0, bus.imem_addr}, 32'h8);
            check("stall_req", {31'b0, bus.imem_req}, 32'd0);
        end
        pc_write = 1'b1;
        step(); step();
        check("slot8", {16'b0, instr_addr_out}, 32'h8);

        pc_write = 1'b0;
        step(); step();
        #3 reset = 1'b0;
        #1;
        check("arst_stall_req", {31'b0, bus.imem_req}, 32'd0);
        check("arst_stall_valid", {31'b0, fetch_valid}, 32'd0);
        check("arst_stall_instr", {16'b0, instruction_out}, 32'h0);
        check("arst_stall_addr", {16'b0, bus.imem_addr}, 32'h0);
        pc_write = 1'b1;
        step();
        reset = 1'b1;
        step(); step(); step(); step();
        check("pc3", {16'b0, bus.imem_addr}, 32'h3);
        branch_taken = 1'b1; branch_target = 16'h0040;
        step();
        branch_taken = 1'b0;
        check("br_flush", {31'b0, if_flush}, 32'd1);
        check("br_valid", {31'b0, fetch_valid}, 32'd0);
        check("br_instr", {16'b0, instruction_out}, 32'h0);
        check("br_addr", {16'b0, bus.imem_addr}, 32'h40);
        step();
        check("br_flush_off", {31'b0, if_flush}, 32'd0);
        check("br_slot", {16'b0, instruction_out}, 32'h1040);

        branch_taken = 1'b1; branch_target = 16'h0080;
        step();
        branch_target = 16'h0090;
        step();
        branch_taken = 1'b0;
        check("b2b_flush", {31'b0, if_flush}, 32'd1);
        check("b2b_addr", {16'b0, bus.imem_addr}, 32'h90);

        for (int i = 0; i < 16; i++) begin
            pc_write = pat_pw[i];
            ready = pat_rd[i];
            step();
        end
        pc_write = 1'b1; ready = 1'b1;
        step(); step();

        #2 reset = 1'b0;
        #1;
        check("arst_fetch_req", {31'b0, bus.imem_req}, 32'd0);
        check("arst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("arst_fetch_iaddr", {16'b0, instr_addr_out}, 32'h0);
        step();
        reset = 1'b1;
        step(); step();
        check("restart_slot", {16'b0, instr_addr_out}, 32'h0);
        check("restart_instr", {16'b0, instruction_out}, 32'h1000);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
